// File: rtl/fwd_hazard_unit.sv
// EX-stage operand forwarding and load-use stall detection over a DEPTH-deep
// shift-register scoreboard of in-flight destinations, with a stall counter.
module fwd_hazard_unit #(
  parameter int unsigned REG_AW     = 5,
  parameter int unsigned DEPTH      = 3,
  parameter int unsigned LOAD_READY = 1,
  parameter int unsigned SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid,
  input  logic [REG_AW-1:0] ex_rd,
  input  logic              ex_regwrite,
  input  logic              ex_load,
  input  logic [REG_AW-1:0] ex_rs,
  input  logic [REG_AW-1:0] ex_rt,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_valid,
  input  logic              hold,
  input  logic              flush,
  output logic [SEL_W-1:0]  fwd_a,
  output logic [SEL_W-1:0]  fwd_b,
  output logic              stall_out,
  output logic [15:0]       stall_count
);

  localparam int unsigned CNT_W = 16;

  logic [DEPTH-1:0]  slot_valid;
  logic [DEPTH-1:0]  slot_rw;
  logic [DEPTH-1:0]  slot_ld;
  logic [REG_AW-1:0] slot_rd [DEPTH];
  logic [CNT_W-1:0]  count_q;

  logic [SEL_W-1:0]  sel_a, sel_b;
  logic              hit_a, hit_b;
  logic              seen_rs, seen_rt;
  logic              stall_rs, stall_rt;

  // Scoreboard shift: flush beats hold, hold freezes, otherwise EX enters slot 0
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_valid <= '0;
      slot_rw    <= '0;
      slot_ld    <= '0;
      for (int k = 0; k < int'(DEPTH); k++) slot_rd[k] <= '0;
    end else if (flush) begin
      slot_valid <= '0;
    end else if (!hold) begin
      for (int k = 1; k < int'(DEPTH); k++) begin
        slot_valid[k] <= slot_valid[k-1];
        slot_rw[k]    <= slot_rw[k-1];
        slot_ld[k]    <= slot_ld[k-1];
        slot_rd[k]    <= slot_rd[k-1];
      end
      slot_valid[0] <= ex_valid;
      slot_rw[0]    <= ex_regwrite;
      slot_ld[0]    <= ex_load;
      slot_rd[0]    <= ex_rd;
    end
  end

  // Youngest writer wins; a load not yet forwardable yields the register file
  always_comb begin
    sel_a = '0;
    sel_b = '0;
    hit_a = 1'b0;
    hit_b = 1'b0;
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!hit_a && slot_valid[k] && slot_rw[k] && slot_rd[k] == ex_rs && ex_rs != '0) begin
        hit_a = 1'b1;
        if (!slot_ld[k] || k >= int'(LOAD_READY)) sel_a = SEL_W'(k + 1);
      end
      if (!hit_b && slot_valid[k] && slot_rw[k] && slot_rd[k] == ex_rt && ex_rt != '0) begin
        hit_b = 1'b1;
        if (!slot_ld[k] || k >= int'(LOAD_READY)) sel_b = SEL_W'(k + 1);
      end
    end
  end

  // Load-use search: EX is distance 0, slot k is distance k+1
  always_comb begin
    seen_rs  = ex_valid && ex_regwrite && ex_rd == id_rs && id_rs != '0;
    seen_rt  = ex_valid && ex_regwrite && ex_rd == id_rt && id_rt != '0;
    stall_rs = seen_rs && ex_load && (LOAD_READY > 0);
    stall_rt = seen_rt && ex_load && (LOAD_READY > 0);
    for (int k = 0; k < int'(DEPTH); k++) begin
      if (!seen_rs && slot_valid[k] && slot_rw[k] && slot_rd[k] == id_rs && id_rs != '0) begin
        seen_rs  = 1'b1;
        stall_rs = slot_ld[k] && (k + 1 < int'(LOAD_READY));
      end
      if (!seen_rt && slot_valid[k] && slot_rw[k] && slot_rd[k] == id_rt && id_rt != '0) begin
        seen_rt  = 1'b1;
        stall_rt = slot_ld[k] && (k + 1 < int'(LOAD_READY));
      end
    end
  end

  assign fwd_a       = sel_a;
  assign fwd_b       = sel_b;
  assign stall_out   = rst_n && id_valid && !flush && (stall_rs || stall_rt);
  assign stall_count = count_q;

  // Saturating performance counter of stalled, non-frozen cycles
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (stall_out && !hold && count_q != {CNT_W{1'b1}}) begin
      count_q <= count_q + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Scoreboard bench for fwd_hazard_unit: LOAD_READY=1 and LOAD_READY=2 instances
// share stimulus; expectations and observations are queued and compared per test.
module tb_fwd_hazard_unit;

  logic       clk, rst_n;
  logic       ex_valid, ex_regwrite, ex_load, id_valid, hold, flush;
  logic [4:0] ex_rd, ex_rs, ex_rt, id_rs, id_rt;
  logic [1:0] fwd_a1, fwd_b1, fwd_a2, fwd_b2;
  logic       stall1, stall2;
  logic [15:0] cnt1, cnt2;

  int n_checks = 0;
  int n_fail   = 0;

  typedef struct {
    string       name;
    int          dut;
    logic [1:0]  a;
    logic [1:0]  b;
    logic        st;
    logic [15:0] cnt;
  } rec_t;

  rec_t exp_q[$];
  rec_t obs_q[$];

  fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_READY(1)) u_lr1 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_load(ex_load), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid), .hold(hold), .flush(flush),
    .fwd_a(fwd_a1), .fwd_b(fwd_b1), .stall_out(stall1), .stall_count(cnt1)
  );

  fwd_hazard_unit #(.REG_AW(5), .DEPTH(3), .LOAD_READY(2)) u_lr2 (
    .clk(clk), .rst_n(rst_n), .ex_valid(ex_valid), .ex_rd(ex_rd),
    .ex_regwrite(ex_regwrite), .ex_load(ex_load), .ex_rs(ex_rs), .ex_rt(ex_rt),
    .id_rs(id_rs), .id_rt(id_rt), .id_valid(id_valid), .hold(hold), .flush(flush),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_out(stall2), .stall_count(cnt2)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic clear_inputs();
    ex_valid = 0; ex_regwrite = 0; ex_load = 0; ex_rd = '0; ex_rs = '0; ex_rt = '0;
    id_valid = 0; id_rs = '0; id_rt = '0; hold = 0; flush = 0;
  endtask

  task automatic set_ex(input logic v, input logic rw, input logic ld, input logic [4:0] rd);
    ex_valid = v; ex_regwrite = rw; ex_load = ld; ex_rd = rd;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    clear_inputs();
    rst_n = 1'b0;
    #2;
    rst_n = 1'b1;
  endtask

  // Queue the expected outputs of one instance and snapshot what it shows now
  task automatic note(input string name, input int dut, input logic [1:0] a, input logic [1:0] b,
                      input logic st, input logic [15:0] cnt);
    rec_t e, o;
    #1;
    e.name = name; e.dut = dut; e.a = a; e.b = b; e.st = st; e.cnt = cnt;
    o = e;
    if (dut == 1) begin
      o.a = fwd_a1; o.b = fwd_b1; o.st = stall1; o.cnt = cnt1;
    end else begin
      o.a = fwd_a2; o.b = fwd_b2; o.st = stall2; o.cnt = cnt2;
    end
    exp_q.push_back(e);
    obs_q.push_back(o);
  endtask

  task automatic test_reset();
    rec_t e, o;
    do_reset();
    set_ex(1, 1, 0, 5'd5);
    tick();
    set_ex(1, 1, 1, 5'd9);
    id_valid = 1; id_rt = 5'd9;
    tick();
    ex_rs = 5'd5;
    note("rst_pre", 1, 2'd2, 2'd0, 1'b1, 16'd1);
    note("rst_pre", 2, 2'd2, 2'd0, 1'b1, 16'd1);
    #1;
    rst_n = 1'b0;
    note("rst_async", 1, 2'd0, 2'd0, 1'b0, 16'd0);
    note("rst_async", 2, 2'd0, 2'd0, 1'b0, 16'd0);
    rst_n = 1'b1;
    clear_inputs();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 4;
      if (o.a !== e.a) begin n_fail++; $display("FAIL %s u%0d fwd_a=%0d expected %0d", e.name, e.dut, o.a, e.a); end
      if (o.b !== e.b) begin n_fail++; $display("FAIL %s u%0d fwd_b=%0d expected %0d", e.name, e.dut, o.b, e.b); end
      if (o.st !== e.st) begin n_fail++; $display("FAIL %s u%0d stall_out=%0b expected %0b", e.name, e.dut, o.st, e.st); end
      if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s u%0d stall_count=%0h expected %0h", e.name, e.dut, o.cnt, e.cnt); end
    end
  endtask

  task automatic test_back_to_back();
    rec_t e, o;
    do_reset();
    set_ex(1, 1, 0, 5'd5);
    tick();
    set_ex(0, 0, 0, 5'd0);
    ex_rs = 5'd5; ex_rt = 5'd5;
    note("alu_slot0", 1, 2'd1, 2'd1, 1'b0, 16'd0);
    tick();
    note("alu_slot1", 1, 2'd2, 2'd2, 1'b0, 16'd0);
    tick();
    note("alu_slot2", 1, 2'd3, 2'd3, 1'b0, 16'd0);
    note("alu_slot2", 2, 2'd3, 2'd3, 1'b0, 16'd0);
    tick();
    note("alu_aged", 1, 2'd0, 2'd0, 1'b0, 16'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 4;
      if (o.a !== e.a) begin n_fail++; $display("FAIL %s u%0d fwd_a=%0d expected %0d", e.name, e.dut, o.a, e.a); end
      if (o.b !== e.b) begin n_fail++; $display("FAIL %s u%0d fwd_b=%0d expected %0d", e.name, e.dut, o.b, e.b); end
      if (o.st !== e.st) begin n_fail++; $display("FAIL %s u%0d stall_out=%0b expected %0b", e.name, e.dut, o.st, e.st); end
      if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s u%0d stall_count=%0h expected %0h", e.name, e.dut, o.cnt, e.cnt); end
    end
  endtask

  task automatic test_priority();
    rec_t e, o;
    do_reset();
    set_ex(1, 1, 0, 5'd7);
    tick();
    set_ex(1, 1, 0, 5'd7);
    tick();
    set_ex(0, 0, 0, 5'd0);
    ex_rs = 5'd7;
    note("prio_young", 1, 2'd1, 2'd0, 1'b0, 16'd0);
    do_reset();
    set_ex(1, 1, 0, 5'd7);
    tick();
    set_ex(1, 0, 0, 5'd7);
    tick();
    set_ex(0, 0, 0, 5'd0);
    ex_rs = 5'd7;
    note("prio_nowrite", 1, 2'd2, 2'd0, 1'b0, 16'd0);
    do_reset();
    set_ex(1, 1, 0, 5'd0);
    tick();
    set_ex(1, 1, 0, 5'd0);
    tick();
    set_ex(0, 0, 0, 5'd0);
    ex_rs = 5'd0; ex_rt = 5'd0;
    note("prio_r0", 1, 2'd0, 2'd0, 1'b0, 16'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 4;
      if (o.a !== e.a) begin n_fail++; $display("FAIL %s u%0d fwd_a=%0d expected %0d", e.name, e.dut, o.a, e.a); end
      if (o.b !== e.b) begin n_fail++; $display("FAIL %s u%0d fwd_b=%0d expected %0d", e.name, e.dut, o.b, e.b); end
      if (o.st !== e.st) begin n_fail++; $display("FAIL %s u%0d stall_out=%0b expected %0b", e.name, e.dut, o.st, e.st); end
      if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s u%0d stall_count=%0h expected %0h", e.name, e.dut, o.cnt, e.cnt); end
    end
  endtask

  task automatic test_load_use();
    rec_t e, o;
    do_reset();
    set_ex(1, 1, 1, 5'd8);
    id_valid = 1; id_rt = 5'd8;
    note("lu_ex", 1, 2'd0, 2'd0, 1'b1, 16'd0);
    note("lu_ex", 2, 2'd0, 2'd0, 1'b1, 16'd0);
    tick();
    set_ex(0, 0, 0, 5'd0);
    note("lu_slot0", 1, 2'd0, 2'd0, 1'b0, 16'd1);
    note("lu_slot0", 2, 2'd0, 2'd0, 1'b1, 16'd1);
    tick();
    id_valid = 0; ex_rt = 5'd8;
    note("lu_slot1", 1, 2'd0, 2'd2, 1'b0, 16'd1);
    note("lu_slot1", 2, 2'd0, 2'd0, 1'b0, 16'd2);
    tick();
    note("lu_slot2", 1, 2'd0, 2'd3, 1'b0, 16'd1);
    note("lu_slot2", 2, 2'd0, 2'd3, 1'b0, 16'd2);
    do_reset();
    set_ex(1, 1, 1, 5'd8);
    id_rt = 5'd8;
    note("lu_noid", 1, 2'd0, 2'd0, 1'b0, 16'd0);
    tick();
    set_ex(1, 1, 0, 5'd8);
    id_valid = 1; id_rs = 5'd8; id_rt = 5'd0;
    note("lu_shadow", 2, 2'd0, 2'd0, 1'b0, 16'd0);
    tick();
    set_ex(0, 0, 0, 5'd0);
    id_valid = 0; ex_rs = 5'd8;
    note("lu_shadow_fwd", 2, 2'd1, 2'd0, 1'b0, 16'd0);
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 4;
      if (o.a !== e.a) begin n_fail++; $display("FAIL %s u%0d fwd_a=%0d expected %0d", e.name, e.dut, o.a, e.a); end
      if (o.b !== e.b) begin n_fail++; $display("FAIL %s u%0d fwd_b=%0d expected %0d", e.name, e.dut, o.b, e.b); end
      if (o.st !== e.st) begin n_fail++; $display("FAIL %s u%0d stall_out=%0b expected %0b", e.name, e.dut, o.st, e.st); end
      if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s u%0d stall_count=%0h expected %0h", e.name, e.dut, o.cnt, e.cnt); end
    end
  endtask

  task automatic test_hold_flush();
    rec_t e, o;
    do_reset();
    set_ex(1, 1, 0, 5'd5);
    tick();
    hold = 1;
    set_ex(1, 1, 1, 5'd9);
    id_valid = 1; id_rt = 5'd9; ex_rs = 5'd5;
    note("hold_0", 1, 2'd1, 2'd0, 1'b1, 16'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      note("hold_n", 1, 2'd1, 2'd0, 1'b1, 16'd0);
    end
    flush = 1;
    note("flush_comb", 1, 2'd1, 2'd0, 1'b0, 16'd0);
    tick();
    note("flush_clr", 1, 2'd0, 2'd0, 1'b0, 16'd0);
    note("flush_clr", 2, 2'd0, 2'd0, 1'b0, 16'd0);
    flush = 0; hold = 0;
    repeat (65534) tick();
    note("sat_fffe", 1, 2'd0, 2'd0, 1'b1, 16'hFFFE);
    tick();
    note("sat_ffff", 1, 2'd0, 2'd0, 1'b1, 16'hFFFF);
    tick();
    tick();
    note("sat_hold", 1, 2'd0, 2'd0, 1'b1, 16'hFFFF);
    note("sat_hold", 2, 2'd0, 2'd0, 1'b1, 16'hFFFF);
    clear_inputs();
    while (exp_q.size() != 0) begin
      e = exp_q.pop_front(); o = obs_q.pop_front();
      n_checks += 4;
      if (o.a !== e.a) begin n_fail++; $display("FAIL %s u%0d fwd_a=%0d expected %0d", e.name, e.dut, o.a, e.a); end
      if (o.b !== e.b) begin n_fail++; $display("FAIL %s u%0d fwd_b=%0d expected %0d", e.name, e.dut, o.b, e.b); end
      if (o.st !== e.st) begin n_fail++; $display("FAIL %s u%0d stall_out=%0b expected %0b", e.name, e.dut, o.st, e.st); end
      if (o.cnt !== e.cnt) begin n_fail++; $display("FAIL %s u%0d stall_count=%0h expected %0h", e.name, e.dut, o.cnt, e.cnt); end
    end
  endtask

  initial begin
    clear_inputs();
    rst_n = 1'b0;
    #12;
    rst_n = 1'b1;
    test_reset();
    test_back_to_back();
    test_priority();
    test_load_use();
    test_hold_flush();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
